pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 149 ++++++++++++++
 tb/tb_pc_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: walks instruction memory, resolves jumps/branches,
// and stalls on input/output handshakes or sleep until the instruction can retire.
module pc_sequencer #(
  parameter int PC_W = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            jump,
  input  logic            branch,
  input  logic            cond,
  input  logic            sleep,
  input  logic            inop,
  input  logic            outop,
  input  logic [PC_W-1:0] jaddr,
  input  logic [PC_W-1:0] baddr,
  input  logic            cmp_flag,
  input  logic            in_valid,
  input  logic            out_ready,
  input  logic            go,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] link_addr,
  output logic            commit,
  output logic            in_ack,
  output logic            out_valid,
  output logic            halted
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    WAIT_IN  = 2'd1,
    WAIT_OUT = 2'd2,
    HALT     = 2'd3
  } state_t;

  state_t          state_r;
  state_t          next_state_s;
  logic [PC_W-1:0] pc_r;
  logic [PC_W-1:0] pc_next_s;
  logic [PC_W-1:0] pc_inc_s;
  logic            taken_s;
  logic            commit_s;
  logic            in_ack_s;
  logic            out_valid_s;

  // Natural wrap of the adder gives the 2^PC_W-1 -> 0 rollover.
  assign pc_inc_s = pc_r + {{(PC_W-1){1'b0}}, 1'b1};
  assign taken_s  = ~cond | cmp_flag;

  // Next-state, next-pc and handshake decode; priority sleep > inop > outop > jump > branch.
  always_comb begin
    next_state_s = state_r;
    pc_next_s    = pc_r;
    commit_s     = 1'b0;
    in_ack_s     = 1'b0;
    out_valid_s  = 1'b0;
    case (state_r)
      RUN: begin
        if (sleep) begin
          next_state_s = HALT;
        end else if (inop) begin
          if (in_valid) begin
            commit_s  = 1'b1;
            in_ack_s  = 1'b1;
            pc_next_s = pc_inc_s;
          end else begin
            next_state_s = WAIT_IN;
          end
        end else if (outop) begin
          out_valid_s = 1'b1;
          if (out_ready) begin
            commit_s  = 1'b1;
            pc_next_s = pc_inc_s;
          end else begin
            next_state_s = WAIT_OUT;
          end
        end else if (jump) begin
          commit_s = 1'b1;
          if (taken_s) begin
            pc_next_s = jaddr;
          end else begin
            pc_next_s = pc_inc_s;
          end
        end else if (branch) begin
          commit_s = 1'b1;
          if (taken_s) begin
            pc_next_s = baddr;
          end else begin
            pc_next_s = pc_inc_s;
          end
        end else begin
          commit_s  = 1'b1;
          pc_next_s = pc_inc_s;
        end
      end
      WAIT_IN: begin
        if (in_valid) begin
          commit_s     = 1'b1;
          in_ack_s     = 1'b1;
          pc_next_s    = pc_inc_s;
          next_state_s = RUN;
        end else begin
          next_state_s = WAIT_IN;
        end
      end
      WAIT_OUT: begin
        out_valid_s = 1'b1;
        if (out_ready) begin
          commit_s     = 1'b1;
          pc_next_s    = pc_inc_s;
          next_state_s = RUN;
        end else begin
          next_state_s = WAIT_OUT;
        end
      end
      HALT: begin
        if (go) begin
          pc_next_s    = pc_inc_s;
          next_state_s = RUN;
        end else begin
          next_state_s = HALT;
        end
      end
      default: begin
        next_state_s = RUN;
        pc_next_s    = pc_r;
      end
    endcase
  end

  // State and program-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= RUN;
      pc_r    <= {PC_W{1'b0}};
    end else begin
      state_r <= next_state_s;
      pc_r    <= pc_next_s;
    end
  end

  // Handshake outputs are masked by rst_n so they drop the instant reset asserts.
  assign pc        = pc_r;
  assign link_addr = pc_inc_s;
  assign commit    = rst_n & commit_s;
  assign in_ack    = rst_n & in_ack_s;
  assign out_valid = rst_n & out_valid_s;
  assign halted    = rst_n & (state_r == HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer with hand-computed expectations.
module tb_pc_sequencer;
  localparam int PC_W = 10;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            jump, branch, cond, sleep, inop, outop;
  logic [PC_W-1:0] jaddr, baddr;
  logic            cmp_flag, in_valid, out_ready, go;
  logic [PC_W-1:0] pc, link_addr;
  logic            commit, in_ack, out_valid, halted;

  int errors = 0;
  int checks = 0;

  pc_sequencer #(.PC_W(PC_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .jump(jump), .branch(branch), .cond(cond), .sleep(sleep),
    .inop(inop), .outop(outop), .jaddr(jaddr), .baddr(baddr),
    .cmp_flag(cmp_flag), .in_valid(in_valid), .out_ready(out_ready), .go(go),
    .pc(pc), .link_addr(link_addr), .commit(commit), .in_ack(in_ack),
    .out_valid(out_valid), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    jump = 1'b0; branch = 1'b0; cond = 1'b0; sleep = 1'b0;
    inop = 1'b0; outop = 1'b0; jaddr = '0; baddr = '0;
    cmp_flag = 1'b0; in_valid = 1'b0; out_ready = 1'b0; go = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    #3;
    check_eq("rst_pc", 16'(pc), 16'h0);
    check_eq("rst_commit", 16'(commit), 16'h0);
    check_eq("rst_halted", 16'(halted), 16'h0);
    check_eq("rst_out_valid", 16'(out_valid), 16'h0);
    check_eq("rst_in_ack", 16'(in_ack), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("link_after_rst", 16'(link_addr), 16'h1);

    // Five plain instructions
    for (int i = 0; i < 5; i++) begin
      check_eq("plain_pc", 16'(pc), 16'(i));
      check_eq("plain_commit", 16'(commit), 16'h1);
      tick();
    end
    check_eq("plain_pc5", 16'(pc), 16'h5);
    tick(); tick();
    check_eq("pc7", 16'(pc), 16'h7);

    // Conditional jump not taken, then taken
    jump = 1'b1; cond = 1'b1; jaddr = 10'h040; cmp_flag = 1'b0;
    #1 check_eq("jmp_nt_commit", 16'(commit), 16'h1);
    tick();
    check_eq("jmp_nt_pc", 16'(pc), 16'h8);
    cond = 1'b0; jaddr = 10'h007;
    tick();
    check_eq("jmp_uncond_pc", 16'(pc), 16'h7);
    cond = 1'b1; jaddr = 10'h040; cmp_flag = 1'b1;
    tick();
    check_eq("jmp_t_pc", 16'(pc), 16'h40);
    cond = 1'b0; cmp_flag = 1'b0;
    #1 check_eq("selfloop_commit", 16'(commit), 16'h1);
    tick();
    check_eq("selfloop_pc", 16'(pc), 16'h40);

    // Branches
    jump = 1'b0; branch = 1'b1; cond = 1'b1; cmp_flag = 1'b0; baddr = 10'h100;
    #1 check_eq("br_nt_commit", 16'(commit), 16'h1);
    tick();
    check_eq("br_nt_pc", 16'(pc), 16'h41);
    cmp_flag = 1'b1; baddr = 10'h003;
    tick();
    check_eq("br_t_pc", 16'(pc), 16'h3);
    idle();

    // Input stall
    inop = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq("win_commit", 16'(commit), 16'h0);
      check_eq("win_ack", 16'(in_ack), 16'h0);
      check_eq("win_pc", 16'(pc), 16'h3);
      tick();
    end
    in_valid = 1'b1;
    #1;
    check_eq("win_ack_pulse", 16'(in_ack), 16'h1);
    check_eq("win_commit_go", 16'(commit), 16'h1);
    check_eq("win_no_outvalid", 16'(out_valid), 16'h0);
    tick();
    check_eq("win_pc_adv", 16'(pc), 16'h4);
    #1 check_eq("win_ack_single", 16'(in_ack), 16'h1);
    inop = 1'b0; in_valid = 1'b0;
    #1 check_eq("ack_drop", 16'(in_ack), 16'h0);
    inop = 1'b1; in_valid = 1'b1;
    tick();
    check_eq("in_direct_pc", 16'(pc), 16'h5);
    idle();

    // Output stall
    outop = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("wout_valid", 16'(out_valid), 16'h1);
      check_eq("wout_commit", 16'(commit), 16'h0);
      check_eq("wout_pc", 16'(pc), 16'h5);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check_eq("wout_valid4", 16'(out_valid), 16'h1);
    check_eq("wout_commit_go", 16'(commit), 16'h1);
    tick();
    check_eq("wout_pc_adv", 16'(pc), 16'h6);
    tick();
    check_eq("out_direct_pc", 16'(pc), 16'h7);
    outop = 1'b0; out_ready = 1'b0;
    #1 check_eq("out_valid_drop", 16'(out_valid), 16'h0);

    // inop outranks outop
    inop = 1'b1; outop = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check_eq("prio_ack", 16'(in_ack), 16'h1);
    check_eq("prio_outvalid", 16'(out_valid), 16'h0);
    tick();
    check_eq("prio_pc", 16'(pc), 16'h8);
    idle();

    // Sleep at top address, wake with wrap
    jump = 1'b1; jaddr = 10'h3FF;
    tick();
    jump = 1'b0;
    check_eq("top_pc", 16'(pc), 16'h3FF);
    check_eq("top_link", 16'(link_addr), 16'h0);
    sleep = 1'b1;
    #1 check_eq("sleep_commit", 16'(commit), 16'h0);
    tick();
    sleep = 1'b0;
    check_eq("halt_flag", 16'(halted), 16'h1);
    check_eq("halt_pc", 16'(pc), 16'h3FF);
    tick();
    check_eq("halt_hold_pc", 16'(pc), 16'h3FF);
    check_eq("halt_commit", 16'(commit), 16'h0);
    go = 1'b1;
    tick();
    go = 1'b0;
    check_eq("wake_pc", 16'(pc), 16'h0);
    check_eq("wake_halted", 16'(halted), 16'h0);

    // Plain increment wrap
    jump = 1'b1; jaddr = 10'h3FF;
    tick();
    jump = 1'b0;
    tick();
    check_eq("wrap_pc", 16'(pc), 16'h0);
    tick();
    check_eq("pc1", 16'(pc), 16'h1);

    // Reset in WAIT_OUT
    outop = 1'b1;
    tick();
    check_eq("wout2_valid", 16'(out_valid), 16'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_wout_valid", 16'(out_valid), 16'h0);
    check_eq("rst_wout_pc", 16'(pc), 16'h0);
    check_eq("rst_wout_commit", 16'(commit), 16'h0);
    idle();
    @(negedge clk);
    rst_n = 1'b1;

    // sleep+jump: sleep wins
    sleep = 1'b1; jump = 1'b1; jaddr = 10'h055;
    #1 check_eq("sj_commit", 16'(commit), 16'h0);
    tick();
    idle();
    check_eq("sj_halted", 16'(halted), 16'h1);
    check_eq("sj_pc", 16'(pc), 16'h0);
    #2;
    rst_n = 1'b0;
    #1 check_eq("rst_halt_drop", 16'(halted), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check_eq("post_rst_commit", 16'(commit), 16'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
